// File: rtl/spi_cmd_tx.sv
// SPI mode-0 command transmitter: sends divider (0x09,lo) or compare (0x08,hi,lo) frames.
// Optional feature: define SPI_CMD_TX_QUEUE_EN for a one-entry request holding register.
module spi_cmd_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_sel,
    input  logic [15:0] i_data,
    output logic        o_ready,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_cs_n,
    output logic        o_sclk,
    output logic        o_mosi,
    output logic        o_tr
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LEAD  = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] GAP   = 3'd3;
    localparam logic [2:0] TRAIL = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [2:0]  state;
    logic [7:0]  div_cnt;
    logic [2:0]  bit_cnt;
    logic [1:0]  byte_idx;
    logic [7:0]  shreg;
    logic        sel_q;
    logic [15:0] data_q;
    logic        sclk_q;
    logic        ready_en;

    logic        accept;
    logic        load_go;
    logic        load_sel;
    logic [15:0] load_data;
    logic        div_end;
    logic        last_byte;
    logic [7:0]  next_byte;

    assign div_end   = (div_cnt == DIV_LAST);
    assign last_byte = sel_q ? (byte_idx == 2'd2) : (byte_idx == 2'd1);
    // Byte following the one currently indexed by byte_idx.
    assign next_byte = (byte_idx == 2'd0 && sel_q) ? data_q[15:8] : data_q[7:0];
    assign accept    = i_start && o_ready;

`ifdef SPI_CMD_TX_QUEUE_EN
    logic        hold_valid;
    logic        hold_sel;
    logic [15:0] hold_data;
    logic        from_hold;
    logic        direct;
    logic        idle_or_done;

    assign idle_or_done = (state == IDLE) || (state == DONE);
    assign from_hold    = (state == DONE) && hold_valid;
    assign direct       = accept && idle_or_done;
    assign load_go      = from_hold || direct;
    assign load_sel     = from_hold ? hold_sel : i_sel;
    assign load_data    = from_hold ? hold_data : i_data;
    assign o_ready      = ready_en && !hold_valid;

    // Requests arriving mid-frame park here until the DONE cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hold_valid <= 1'b0;
            hold_sel   <= 1'b0;
            hold_data  <= 16'h0000;
        end else if (accept && !idle_or_done) begin
            hold_valid <= 1'b1;
            hold_sel   <= i_sel;
            hold_data  <= i_data;
        end else if (from_hold) begin
            hold_valid <= 1'b0;
        end
    end
`else
    assign load_go   = accept;
    assign load_sel  = i_sel;
    assign load_data = i_data;
    assign o_ready   = ready_en && (state == IDLE);
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            div_cnt  <= 8'd0;
            bit_cnt  <= 3'd0;
            byte_idx <= 2'd0;
            shreg    <= 8'h00;
            sel_q    <= 1'b0;
            data_q   <= 16'h0000;
            sclk_q   <= 1'b0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            case (state)
                IDLE, DONE: begin
                    if (load_go) begin
                        state    <= LEAD;
                        sel_q    <= load_sel;
                        data_q   <= load_data;
                        shreg    <= load_sel ? 8'h08 : 8'h09;
                        byte_idx <= 2'd0;
                        div_cnt  <= 8'd0;
                    end else begin
                        state <= IDLE;
                    end
                end
                LEAD, GAP: begin
                    if (div_end) begin
                        state   <= SHIFT;
                        div_cnt <= 8'd0;
                        bit_cnt <= 3'd0;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                SHIFT: begin
                    if (!div_end) begin
                        div_cnt <= div_cnt + 8'd1;
                    end else begin
                        div_cnt <= 8'd0;
                        sclk_q  <= !sclk_q;
                        // Data advances on the falling edge so it is stable across the rise.
                        if (sclk_q) begin
                            if (bit_cnt == 3'd7) begin
                                if (last_byte) begin
                                    state <= TRAIL;
                                    shreg <= 8'h00;
                                end else begin
                                    state    <= GAP;
                                    byte_idx <= byte_idx + 2'd1;
                                    shreg    <= next_byte;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                shreg   <= {shreg[6:0], 1'b0};
                            end
                        end
                    end
                end
                TRAIL: begin
                    if (div_end) begin
                        state   <= DONE;
                        div_cnt <= 8'd0;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_cs_n = !((state == LEAD) || (state == SHIFT) || (state == GAP) || (state == TRAIL));
    assign o_sclk = sclk_q;
    assign o_tr   = (state == SHIFT);
    assign o_mosi = !o_cs_n && shreg[7];
    assign o_done = (state == DONE);
    assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_spi_cmd_tx.sv
// Self-checking bench for spi_cmd_tx: decodes the SPI wire activity and compares it
// against frame contents and timing computed from the command format.
module tb_spi_cmd_tx;

    localparam int DIV = 4;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic        sel   = 1'b0;
    logic [15:0] data  = 16'h0000;
    logic        ready, busy, done, cs_n, sclk, mosi, tr;

    int vectors     = 0;
    int miscompares = 0;

    // Wire-level observations collected by the monitor.
    logic [7:0] byte_q[$];
    int         cs_len_q[$];
    int         cs_high_q[$];
    int         tr_falls    = 0;
    int         done_cnt    = 0;
    int         mosi_viol   = 0;
    int         ready_viol  = 0;
    int         cs_low_run  = 0;
    int         cs_high_run = 0;
    int         bit_n       = 0;
    logic [7:0] cur         = 8'h00;
    logic       prev_cs     = 1'b1;
    logic       prev_sclk   = 1'b0;
    logic       prev_tr     = 1'b0;

    spi_cmd_tx #(.CLK_DIV(DIV)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_start(start),
        .i_sel  (sel),
        .i_data (data),
        .o_ready(ready),
        .o_busy (busy),
        .o_done (done),
        .o_cs_n (cs_n),
        .o_sclk (sclk),
        .o_mosi (mosi),
        .o_tr   (tr)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Sample away from the active edge; capture MOSI on each SCLK rise while selected.
    always @(negedge clk) begin
        if (!cs_n) begin
            if (prev_cs) cs_high_q.push_back(cs_high_run);
            cs_high_run = 0;
            cs_low_run++;
            if (sclk && !prev_sclk) begin
                cur = {cur[6:0], mosi};
                bit_n++;
                if (bit_n == 8) begin
                    byte_q.push_back(cur);
                    bit_n = 0;
                end
            end
        end else begin
            if (!prev_cs) cs_len_q.push_back(cs_low_run);
            cs_low_run = 0;
            bit_n      = 0;
            cs_high_run++;
            if (mosi) mosi_viol++;
        end
        if (prev_tr && !tr) tr_falls++;
        if (done) done_cnt++;
        if (busy && ready) ready_viol++;
        prev_cs   = cs_n;
        prev_sclk = sclk;
        prev_tr   = tr;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, expv);
        end
    endtask

    function automatic int numBytes(input logic s);
        return s ? 3 : 2;
    endfunction

    function automatic logic [7:0] expByte(input logic s, input logic [15:0] d, input int i);
        logic [7:0] b[3];
        b[0] = s ? 8'h08 : 8'h09;
        b[1] = s ? d[15:8] : d[7:0];
        b[2] = d[7:0];
        return b[i];
    endfunction

    function automatic int expCsLen(input int n);
        return DIV * (1 + 16 * n + (n - 1) + 1);
    endfunction

    task automatic waitReady();
        int n;
        n = 0;
        while (!ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!ready) checkOutput("ready_timeout", 32'(ready), 32'd1);
    endtask

    task automatic applyStimulus(input logic s, input logic [15:0] d);
        waitReady();
        sel   = s;
        data  = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for the given number of o_done pulses, optionally disturbing inputs meanwhile.
    task automatic waitDone(input int pulses, input bit scramble, input bit pester);
        int seen;
        int n;
        seen = 0;
        n    = 0;
        while (seen < pulses && n < 5000) begin
            @(negedge clk);
            n++;
            if (done) begin
                seen++;
            end else begin
                if (scramble) begin
                    sel  = 1'($urandom_range(0, 1));
                    data = 16'($urandom);
                end
                if (pester) start = 1'($urandom_range(0, 1));
            end
        end
        start = 1'b0;
        if (seen < pulses) checkOutput("done_timeout", 32'(seen), 32'(pulses));
        repeat (2) @(negedge clk);
    endtask

    task automatic runFrame(input logic s, input logic [15:0] d, input bit scramble, input bit pester);
        int b0, c0, t0, d0, m0, r0, n;
        b0 = byte_q.size();
        c0 = cs_len_q.size();
        t0 = tr_falls;
        d0 = done_cnt;
        m0 = mosi_viol;
        r0 = ready_viol;
        n  = numBytes(s);
        applyStimulus(s, d);
        waitDone(1, scramble, pester);
        checkOutput("nbytes", 32'(byte_q.size() - b0), 32'(n));
        for (int i = 0; i < n; i++)
            if (b0 + i < byte_q.size())
                checkOutput($sformatf("byte%0d", i), 32'(byte_q[b0 + i]), 32'(expByte(s, d, i)));
        checkOutput("tr_falls", 32'(tr_falls - t0), 32'(n));
        checkOutput("frames", 32'(cs_len_q.size() - c0), 32'd1);
        checkOutput("cs_len", (cs_len_q.size() > c0) ? 32'(cs_len_q[c0]) : 32'd0, 32'(expCsLen(n)));
        checkOutput("done_pulses", 32'(done_cnt - d0), 32'd1);
        checkOutput("mosi_idle", 32'(mosi_viol - m0), 32'd0);
`ifndef SPI_CMD_TX_QUEUE_EN
        checkOutput("ready_while_busy", 32'(ready_viol - r0), 32'd0);
`endif
    endtask

    task automatic resetMidFrame();
        int b0, d0;
        logic [15:0] d;
        d  = 16'hBEEF;
        b0 = byte_q.size();
        d0 = done_cnt;
        applyStimulus(1'b1, d);
        repeat (24 * DIV + 2) @(negedge clk);
        checkOutput("pre_rst_bytes", 32'(byte_q.size() - b0), 32'd1);
        checkOutput("pre_rst_tr", 32'(tr), 32'd1);
        rst   = 1'b1;
        start = 1'b1;
        data  = 16'($urandom);
        @(negedge clk);
        checkOutput("abort_cs_n", 32'(cs_n), 32'd1);
        checkOutput("abort_sclk", 32'(sclk), 32'd0);
        checkOutput("abort_tr", 32'(tr), 32'd0);
        checkOutput("abort_mosi", 32'(mosi), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_ready", 32'(ready), 32'd1);
        repeat (5) @(negedge clk);
        checkOutput("post_rst_busy", 32'(busy), 32'd0);
        checkOutput("abort_no_done", 32'(done_cnt - d0), 32'd0);
        runFrame(1'b1, d, 1'b0, 1'b0);
    endtask

`ifdef SPI_CMD_TX_QUEUE_EN
    task automatic queuedPair();
        int b0, c0, h0, d0;
        logic [7:0] expq[5];
        expq = '{8'h08, 8'h12, 8'h34, 8'h09, 8'hFF};
        b0 = byte_q.size();
        c0 = cs_len_q.size();
        h0 = cs_high_q.size();
        d0 = done_cnt;
        applyStimulus(1'b1, 16'h1234);
        repeat (20) @(negedge clk);
        applyStimulus(1'b0, 16'h00FF);
        checkOutput("holder_full_ready", 32'(ready), 32'd0);
        waitDone(2, 1'b1, 1'b0);
        checkOutput("q_nbytes", 32'(byte_q.size() - b0), 32'd5);
        for (int i = 0; i < 5; i++)
            if (b0 + i < byte_q.size())
                checkOutput($sformatf("q_byte%0d", i), 32'(byte_q[b0 + i]), 32'(expq[i]));
        checkOutput("q_frames", 32'(cs_len_q.size() - c0), 32'd2);
        checkOutput("q_cs_high_gap", (cs_high_q.size() > h0 + 1) ? 32'(cs_high_q[h0 + 1]) : 32'd0, 32'd1);
        checkOutput("q_done_pulses", 32'(done_cnt - d0), 32'd2);
    endtask
`endif

    initial begin
        bit pester;
`ifdef SPI_CMD_TX_QUEUE_EN
        pester = 1'b0;
`else
        pester = 1'b1;
`endif
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_cs_n", 32'(cs_n), 32'd1);
        checkOutput("rst_sclk", 32'(sclk), 32'd0);
        checkOutput("rst_mosi", 32'(mosi), 32'd0);
        checkOutput("rst_tr", 32'(tr), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_ready", 32'(ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_release", 32'(ready), 32'd1);

        runFrame(1'b0, 16'h00A5, 1'b0, 1'b0);
        runFrame(1'b1, 16'h1234, 1'b0, 1'b0);
        runFrame(1'b0, 16'h5A3C, 1'b1, pester);

        for (int k = 0; k < 6; k++)
            runFrame(1'($urandom_range(0, 1)), 16'($urandom), 1'b1, pester);

`ifdef SPI_CMD_TX_QUEUE_EN
        queuedPair();
`endif
        resetMidFrame();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
